uart_cmd_ctrl: RTL

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// Byte-oriented command front end: 'W' addr data / 'R' addr frames from a UART
// are turned into register bus strobes, answered with ACK, read data or NAK.
module uart_cmd_ctrl #(
  parameter int CLK_FREQ = 25000000,
  parameter int TIMEOUT  = 250000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iRxData,
  input  logic       iRxValid,
  output logic [7:0] oTxData,
  output logic       oTxValid,
  input  logic       iTxBusy,
  output logic [7:0] oAddr,
  output logic [7:0] oWData,
  output logic       oWr,
  output logic       oRd,
  input  logic [7:0] iRData,
  input  logic       iAck,
  output logic       oBusy,
  output logic       oErr
);

  if (TIMEOUT < 2 || TIMEOUT > 16777215) begin : g_bad_timeout
    $error("uart_cmd_ctrl: TIMEOUT must lie in 2..16777215");
  end
  if (CLK_FREQ <= 0) begin : g_bad_clk
    $error("uart_cmd_ctrl: CLK_FREQ must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  localparam logic [7:0]  CMD_W   = 8'h57;
  localparam logic [7:0]  CMD_R   = 8'h52;
  localparam logic [7:0]  RSP_ACK = 8'h06;
  localparam logic [7:0]  RSP_NAK = 8'h15;
  localparam logic [23:0] T_LAST  = 24'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [23:0] timer, timer_n;
  logic [7:0]  addr, addr_n;
  logic [7:0]  wdata, wdata_n;
  logic [7:0]  resp, resp_n;
  logic        is_wr, is_wr_n;
  logic        wr, wr_n;
  logic        rd, rd_n;
  logic        err, err_n;
  logic        tx_fire;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_IDLE;
      timer <= '0;
      addr  <= '0;
      wdata <= '0;
      resp  <= '0;
      is_wr <= 1'b0;
      wr    <= 1'b0;
      rd    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      resp  <= resp_n;
      is_wr <= is_wr_n;
      wr    <= wr_n;
      rd    <= rd_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    addr_n  = addr;
    wdata_n = wdata;
    resp_n  = resp;
    is_wr_n = is_wr;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    err_n   = 1'b0;
    tx_fire = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (iRxValid) begin
          if (iRxData == CMD_W || iRxData == CMD_R) begin
            is_wr_n = (iRxData == CMD_W);
            state_n = S_ADDR;
          end else begin
            resp_n  = RSP_NAK;
            err_n   = 1'b1;
            state_n = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (iRxValid) begin
          addr_n  = iRxData;
          timer_n = '0;
          if (is_wr) begin
            state_n = S_DATA;
          end else begin
            rd_n    = 1'b1;
            state_n = S_BUS;
          end
        end else if (timer == T_LAST) begin
          timer_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + 24'd1;
        end
      end
      S_DATA: begin
        if (iRxValid) begin
          wdata_n = iRxData;
          timer_n = '0;
          wr_n    = 1'b1;
          state_n = S_BUS;
        end else if (timer == T_LAST) begin
          timer_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + 24'd1;
        end
      end
      S_BUS: begin
        // The strobe cycle itself never counts as an acknowledge.
        if (iAck && !(wr || rd)) begin
          resp_n  = is_wr ? RSP_ACK : iRData;
          timer_n = '0;
          state_n = S_RESP;
        end else if (timer == T_LAST) begin
          resp_n  = RSP_NAK;
          err_n   = 1'b1;
          timer_n = '0;
          state_n = S_RESP;
        end else begin
          timer_n = timer + 24'd1;
        end
      end
      S_RESP: begin
        if (!iTxBusy) begin
          tx_fire = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Strobes are masked while reset is held so nothing leaks out in its first cycle.
  assign oAddr    = addr;
  assign oWData   = wdata;
  assign oTxData  = resp;
  assign oWr      = wr & ~iRst;
  assign oRd      = rd & ~iRst;
  assign oErr     = err & ~iRst;
  assign oTxValid = tx_fire & ~iRst;
  assign oBusy    = (state != S_IDLE) & ~iRst;

endmodule
